// File: rtl/rob_commit_if.sv
// Issue / completion / commit bundle for the eonv reorder buffer.
// rob_commit drives the slave side.
interface rob_commit_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8,
  parameter int NTF   = 2
);
  localparam int BITS = $clog2(SIZE);

  logic [4:0]          rl;
  logic [4:0]          rr;
  logic [1:0]          rob_wait;
  logic [1:0]          rob_rdy;
  logic [BITS-1:0]     rob_rl;
  logic [BITS-1:0]     rob_rr;
  logic [WIDTH-1:0]    rob_vl;
  logic [WIDTH-1:0]    rob_vr;
  logic [BITS-1:0]     rob_next;
  logic                full;
  logic [BITS:0]       count;
  logic                new_req;
  logic [2:0]          itype;
  logic [4:0]          rno_i;
  logic [WIDTH-1:0]    imm;
  logic [WIDTH-1:0]    pc_i;
  logic [NTF-1:0]      ntf;
  logic [3*NTF-1:0]    exc_n;
  logic [WIDTH*NTF-1:0] val;
  logic [BITS*NTF-1:0] at;
  logic                cvalid;
  logic [4:0]          rno;
  logic [2:0]          exc;
  logic [2:0]          ctype;
  logic [WIDTH-1:0]    pc;
  logic [WIDTH-1:0]    rval;
  logic [BITS-1:0]     rbus;
  logic                flush;

  modport master (
    output rl, rr, new_req, itype, rno_i, imm, pc_i,
    output ntf, exc_n, val, at,
    input  rob_wait, rob_rdy, rob_rl, rob_rr, rob_vl, rob_vr,
    input  rob_next, full, count,
    input  cvalid, rno, exc, ctype, pc, rval, rbus, flush
  );

  modport slave (
    input  rl, rr, new_req, itype, rno_i, imm, pc_i,
    input  ntf, exc_n, val, at,
    output rob_wait, rob_rdy, rob_rl, rob_rr, rob_vl, rob_vr,
    output rob_next, full, count,
    output cvalid, rno, exc, ctype, pc, rval, rbus, flush
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with NTF completion ports, operand forwarding,
// in-order single commit and full flush on an excepting commit.
module rob_commit #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8,
  parameter int NTF   = 2
) (
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave bus
);
  localparam int BITS = $clog2(SIZE);
  localparam logic [4:0] R_ZERO = 5'd0;
  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [BITS:0] FULL_CNT = (BITS+1)'(SIZE);

  logic [SIZE-1:0]  busy;
  logic [2:0]       typ_q [SIZE];
  logic [4:0]       rno_q [SIZE];
  logic [2:0]       exc_q [SIZE];
  logic [WIDTH-1:0] pc_q  [SIZE];
  logic [WIDTH-1:0] val_q [SIZE];
  logic [31:0]      rrob;
  logic [BITS-1:0]  rmap  [32];
  logic [BITS-1:0]  head;
  logic [BITS-1:0]  tail;
  logic [BITS:0]    cnt;

  logic do_commit;
  logic flush_now;
  logic do_alloc;

  assign do_commit = (cnt != '0) && !busy[head];
  assign flush_now = do_commit && (exc_q[head] != EXC_NONE);
  assign do_alloc  = bus.new_req && (cnt != FULL_CNT) && !flush_now;

  assign bus.rob_wait = {rrob[bus.rl], rrob[bus.rr]};
  assign bus.rob_rdy  = {rrob[bus.rl] & ~busy[rmap[bus.rl]],
                         rrob[bus.rr] & ~busy[rmap[bus.rr]]};
  assign bus.rob_rl   = rmap[bus.rl];
  assign bus.rob_rr   = rmap[bus.rr];
  assign bus.rob_vl   = val_q[rmap[bus.rl]];
  assign bus.rob_vr   = val_q[rmap[bus.rr]];
  assign bus.rob_next = tail;
  assign bus.full     = (cnt == FULL_CNT);
  assign bus.count    = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      rrob       <= '0;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      bus.cvalid <= 1'b0;
      bus.flush  <= 1'b0;
      bus.rno    <= R_ZERO;
      bus.exc    <= EXC_NONE;
      bus.ctype  <= '0;
      bus.pc     <= '0;
      bus.rval   <= '0;
      bus.rbus   <= '0;
    end else begin
      bus.cvalid <= do_commit;
      bus.flush  <= flush_now;
      if (do_commit) begin
        bus.rno   <= rno_q[head];
        bus.exc   <= exc_q[head];
        bus.ctype <= typ_q[head];
        bus.pc    <= pc_q[head];
        bus.rval  <= val_q[head];
        bus.rbus  <= head;
        head      <= head + BITS'(1);
        if (rmap[rno_q[head]] == head)
          rrob[rno_q[head]] <= 1'b0;
      end
      // allocation after the commit clear so a same-rno alloc wins
      if (do_alloc) begin
        busy[tail] <= 1'b1;
        tail       <= tail + BITS'(1);
        if (bus.rno_i != R_ZERO)
          rrob[bus.rno_i] <= 1'b1;
      end
      if (!flush_now) begin
        for (int k = 0; k < NTF; k++) begin
          if (bus.ntf[k] && busy[bus.at[k*BITS +: BITS]])
            busy[bus.at[k*BITS +: BITS]] <= 1'b0;
        end
      end
      cnt <= cnt + (BITS+1)'(do_alloc) - (BITS+1)'(do_commit);
      if (flush_now) begin
        busy <= '0;
        rrob <= '0;
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end
    end
  end

  // payload storage; later ports overwrite earlier ones on a shared tag
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      typ_q[tail] <= bus.itype;
      rno_q[tail] <= bus.rno_i;
      pc_q[tail]  <= bus.pc_i;
      val_q[tail] <= bus.imm;
      exc_q[tail] <= EXC_NONE;
      if (bus.rno_i != R_ZERO)
        rmap[bus.rno_i] <= tail;
    end
    if (!flush_now) begin
      for (int k = 0; k < NTF; k++) begin
        if (bus.ntf[k] && busy[bus.at[k*BITS +: BITS]]) begin
          exc_q[bus.at[k*BITS +: BITS]] <= bus.exc_n[3*k +: 3];
          if (bus.exc_n[3*k +: 3] == EXC_NONE)
            val_q[bus.at[k*BITS +: BITS]] <= bus.val[k*WIDTH +: WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: expected commits are queued when
// the completing notify is driven and popped on each cvalid.
module tb_rob_commit;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_commit_if #(.WIDTH(32), .SIZE(8), .NTF(2)) bus ();

  rob_commit #(.WIDTH(32), .SIZE(8), .NTF(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rno;
    logic [2:0]  exc;
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] v;
    logic [2:0]  tag;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [2:0] e,
                      input logic [2:0] t, input logic [31:0] p,
                      input logic [31:0] v, input logic [2:0] g);
    exp_t x;
    x.rno = r; x.exc = e; x.typ = t; x.pc = p; x.v = v; x.tag = g;
    sb.push_back(x);
  endtask

  task automatic alloc(input logic [4:0] r, input logic [31:0] p,
                       input logic [31:0] im, input logic [2:0] t);
    bus.new_req = 1'b1;
    bus.rno_i   = r;
    bus.pc_i    = p;
    bus.imm     = im;
    bus.itype   = t;
    tick();
    bus.new_req = 1'b0;
  endtask

  task automatic notify(input logic [1:0] en,
                        input logic [2:0] t0, input logic [2:0] t1,
                        input logic [31:0] v0, input logic [31:0] v1,
                        input logic [2:0] e0, input logic [2:0] e1);
    bus.ntf   = en;
    bus.at    = {t1, t0};
    bus.val   = {v1, v0};
    bus.exc_n = {e1, e0};
    tick();
    bus.ntf = '0;
  endtask

  always @(negedge clk) begin
    if (bus.cvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_cvalid", bus.cvalid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("c_rno", bus.rno, e.rno);
        chk("c_exc", bus.exc, e.exc);
        chk("c_type", bus.ctype, e.typ);
        chk("c_pc", bus.pc, e.pc);
        chk("c_val", bus.rval, e.v);
        chk("c_tag", bus.rbus, e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b1;
    bus.rl = 5'd3; bus.rr = 5'd5;
    bus.new_req = 1'b0; bus.itype = '0; bus.rno_i = '0;
    bus.imm = '0; bus.pc_i = '0;
    bus.ntf = '0; bus.exc_n = '0; bus.val = '0; bus.at = '0;
    tick();
    chk("rst_wait", bus.rob_wait, 2'b00);
    chk("rst_rdy", bus.rob_rdy, 2'b00);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_cvalid", bus.cvalid, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_rval", bus.rval, 0);
    chk("rst_next", bus.rob_next, 0);
    rst = 1'b0;

    // basic flow
    alloc(5'd3, 32'h100, 32'h0, 3'd1);
    chk("b_wait", bus.rob_wait, 2'b10);
    chk("b_rdy0", bus.rob_rdy, 2'b00);
    chk("b_count", bus.count, 1);
    chk("b_tag", bus.rob_rl, 0);
    push(5'd3, 3'd0, 3'd1, 32'h100, 32'h55, 3'd0);
    notify(2'b01, 3'd0, 3'd0, 32'h55, 32'h0, 3'd0, 3'd0);
    chk("b_rdy1", bus.rob_rdy, 2'b10);
    chk("b_fwd", bus.rob_vl, 32'h55);
    chk("b_nocv", bus.cvalid, 0);
    tick();
    chk("b_cv", bus.cvalid, 1);
    chk("b_wait2", bus.rob_wait, 2'b00);
    chk("b_count2", bus.count, 0);

    // out-of-order completion
    bus.rl = 5'd1; bus.rr = 5'd2;
    alloc(5'd1, 32'h200, 32'ha, 3'd2);
    alloc(5'd2, 32'h204, 32'hb, 3'd3);
    alloc(5'd1, 32'h208, 32'hc, 3'd4);
    chk("o_wait", bus.rob_wait, 2'b11);
    chk("o_rl", bus.rob_rl, 3);
    chk("o_rr", bus.rob_rr, 2);
    chk("o_rdy0", bus.rob_rdy, 2'b00);
    push(5'd1, 3'd0, 3'd2, 32'h200, 32'h11, 3'd1);
    push(5'd2, 3'd0, 3'd3, 32'h204, 32'h22, 3'd2);
    push(5'd1, 3'd0, 3'd4, 32'h208, 32'h33, 3'd3);
    notify(2'b11, 3'd2, 3'd3, 32'h22, 32'h33, 3'd0, 3'd0);
    chk("o_rdy1", bus.rob_rdy, 2'b11);
    chk("o_vl", bus.rob_vl, 32'h33);
    chk("o_vr", bus.rob_vr, 32'h22);
    notify(2'b01, 3'd1, 3'd0, 32'h11, 32'h0, 3'd0, 3'd0);
    tick();
    chk("o_wait1", bus.rob_wait, 2'b11);
    tick();
    chk("o_wait2", bus.rob_wait, 2'b10);
    tick();
    chk("o_wait3", bus.rob_wait, 2'b00);

    // full and wrap from a clean state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("w_next0", bus.rob_next, 0);
    for (int i = 0; i < 8; i++)
      alloc(5'(8 + i), 32'h500 + 32'(4 * i), 32'h0, 3'(i));
    chk("w_full", bus.full, 1);
    chk("w_count", bus.count, 8);
    alloc(5'd20, 32'h5ff, 32'h0, 3'd0);
    chk("w_rej_next", bus.rob_next, 0);
    chk("w_rej_count", bus.count, 8);
    for (int i = 0; i < 8; i++)
      push(5'(8 + i), 3'd0, 3'(i), 32'h500 + 32'(4 * i),
           32'h1000 + 32'(i), 3'(i));
    notify(2'b11, 3'd0, 3'd1, 32'h1000, 32'h1001, 3'd0, 3'd0);
    bus.new_req = 1'b1;
    bus.rno_i = 5'd20;
    notify(2'b11, 3'd2, 3'd3, 32'h1002, 32'h1003, 3'd0, 3'd0);
    bus.new_req = 1'b0;
    chk("w_fullcommit_cnt", bus.count, 7);
    chk("w_fullcommit_next", bus.rob_next, 0);
    notify(2'b11, 3'd4, 3'd5, 32'h1004, 32'h1005, 3'd0, 3'd0);
    notify(2'b11, 3'd6, 3'd7, 32'h1006, 32'h1007, 3'd0, 3'd0);
    for (int i = 0; i < 20 && bus.count != 0; i++) tick();
    chk("w_drain", bus.count, 0);
    chk("w_notfull", bus.full, 0);
    bus.rl = 5'd1; bus.rr = 5'd3;
    alloc(5'd1, 32'h600, 32'h0, 3'd0);
    alloc(5'd2, 32'h604, 32'h0, 3'd0);
    alloc(5'd3, 32'h608, 32'h0, 3'd0);
    chk("w_re_count", bus.count, 3);
    chk("w_re_next", bus.rob_next, 3);
    chk("w_re_rl", bus.rob_rl, 0);
    chk("w_re_rr", bus.rob_rr, 2);

    // reset with pending entries
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_count", bus.count, 0);
    chk("r_wait", bus.rob_wait, 2'b00);
    chk("r_cvalid", bus.cvalid, 0);
    tick();

    // exception flush
    bus.rl = 5'd4; bus.rr = 5'd7;
    for (int i = 0; i < 4; i++)
      alloc(5'(4 + i), 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 3'd5);
    push(5'd4, 3'd0, 3'd5, 32'h300, 32'h77, 3'd0);
    push(5'd5, 3'd2, 3'd5, 32'h304, 32'h1001, 3'd1);
    notify(2'b01, 3'd1, 3'd0, 32'h99, 32'h0, 3'd2, 3'd0);
    notify(2'b01, 3'd0, 3'd0, 32'h77, 32'h0, 3'd0, 3'd0);
    tick();
    chk("f_noflush", bus.flush, 0);
    bus.new_req = 1'b1;
    bus.rno_i = 5'd9;
    tick();
    bus.new_req = 1'b0;
    chk("f_flush", bus.flush, 1);
    chk("f_cvalid", bus.cvalid, 1);
    chk("f_count", bus.count, 0);
    chk("f_next", bus.rob_next, 0);
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      bus.rl = 5'(r);
      #1;
      if (bus.rob_wait != 2'b00) bad++;
    end
    chk("f_wait_all", bad, 0);
    tick();
    chk("f_pulse", bus.flush, 0);

    // duplicate notify: higher port wins
    alloc(5'd6, 32'h400, 32'h0, 3'd6);
    push(5'd6, 3'd0, 3'd6, 32'h400, 32'h22, 3'd0);
    notify(2'b11, 3'd0, 3'd0, 32'h11, 32'h22, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("sb_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit unit for the eonv core. It is the parametrised successor of the single-notify commit stage, and sits between issue (allocation, operand status query) and the register file / exception logic (commit broadcast). Relative to the earlier stage it adds:
- NTF parallel completion ports;
- count-based full/empty with all SIZE entries usable;
- operand value forwarding from completed-but-uncommitted entries;
- a full ROB flush when an excepting instruction commits.

## Interface
Parameters:
- WIDTH, 32, datapath/value/pc width
- SIZE, 8, ROB entries; power of two, at least 2; BITS = $clog2(SIZE)
- NTF, 2, completion notification ports

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rl, rr  in  5 each  architectural source registers to query
- rob_wait  out  2  {pending(rl), pending(rr)}: register has an uncommitted producer
- rob_rdy  out  2  {rdy(rl), rdy(rr)}: producer pending and no longer busy
- rob_rl, rob_rr  out  BITS each  ROB tag of the producer
- rob_vl, rob_vr  out  WIDTH each  value of the producer entry
- rob_next  out  BITS  tag the next allocation receives (tail)
- full  out  1  count == SIZE
- count  out  BITS+1  occupied entries
- new  in  1  allocation request
- type  in  3  instruction kind, stored and returned at commit
- rno_i  in  5  destination register
- imm  in  WIDTH  initial entry value
- pc_i  in  WIDTH  instruction pc
- ntf  in  NTF  per-port completion strobe
- exc_n  in  3*NTF  port k uses bits [3k+2:3k]
- val  in  WIDTH*NTF  port k result
- at  in  BITS*NTF  port k target tag
- cvalid  out  1  commit broadcast valid
- rno  out  5  committed destination register
- exc  out  3  committed exception code
- ctype  out  3  committed kind
- pc  out  WIDTH  committed pc
- rval  out  WIDTH  committed value
- rbus  out  BITS  committed tag
- flush  out  1  ROB flushed this cycle

## Operation
**Register map.** rrob[32] pending bits and rmap[32] tags.
- Query outputs are combinational from state: rob_wait = rrob[r]; rob_rdy = rrob[r] & !busy[rmap[r]]; rob_v* = val[rmap[r]].
- R_ZERO is never marked pending.

**Allocation.** Accepted when new & !full & !flush_now.
- Write busy=1, typ, rno, pc and val=imm into entry [tail]; tail+1 modulo SIZE.
- If rno_i != R_ZERO: rmap[rno_i] <= tail and rrob[rno_i] <= 1.

**Notify.** For each port k with ntf[k] and busy[at_k]=1:
- busy <= 0 and exc <= exc_k;
- val <= val_k only when exc_k == EXC_NONE.
- Notify to a non-busy entry is ignored.
- If two ports target the same tag, the higher index k wins.

**Commit.** When count != 0 and busy[head] == 0:
- register the head entry onto the outputs, cvalid <= 1, head+1;
- if rmap[rno[head]] == head, clear rrob[rno[head]].
- At most one commit per cycle.

**Flush.** A commit whose exc != EXC_NONE broadcasts normally and also, in the same edge:
- sets flush <= 1 and head, tail, count <= 0;
- clears all rrob and busy bits;
- ignores any allocation or notify in that cycle.
- flush_now is the combinational flush condition.

**Count.** count <= count + alloc - commit. Overflow and underflow cannot occur.

## Timing
- **Reset values:** cvalid=0, flush=0, rno=R_ZERO, exc=EXC_NONE, ctype=0, pc=0, rval=0, rbus=0, head=tail=count=0. All rrob and busy bits are 0, so rob_wait=rob_rdy=0 and full=0.
- **Latencies:**
  - Allocation at edge N: entry and map are visible from N.
  - Earliest notify is sampled at edge N+1.
  - A head entry notified at edge E is broadcast by the registers at edge E+1, so cvalid is high in cycle E+1..E+2.
  - cvalid and flush are single-cycle pulses. Other commit outputs hold their last value.
- **Full:** from registered count; no same-cycle bypass. An allocation at full is rejected even if a commit occurs that cycle.
- **Empty:** count == 0 means no commit. Allocation and notify of the same entry in one cycle is impossible (notify needs a prior allocation).
- **Simultaneous alloc + commit on the same rno:** the allocation wins; rrob stays 1 and rmap takes the new tag.
- **Notify + commit-check of head in the same cycle:** commit uses pre-edge busy, so head commits one cycle later.
- **Wrap-around:** head and tail wrap modulo SIZE. With SIZE entries all allocated, head == tail and count == SIZE.
- **Reset mid-operation:** all state returns to reset values at the next edge. Pending entries are discarded and no broadcast is produced.

## Test plan
- **Reset then query:** rst 1 cycle, rl=3, rr=5 -> rob_wait=00, full=0, count=0, cvalid=0, flush=0.
- **Basic flow:** alloc R3 pc=0x100 imm=0; notify tag0 val=0x55 exc=0 -> rob_rdy[1]=1 and rob_vl=0x55 before commit; next cycle cvalid=1, rno=3, rval=0x55, rbus=0; then rob_wait[1]=0.
- **Out-of-order completion:** alloc 3 entries (R1,R2,R1); notify tags 2 and 1 on ports 1 and 0 in the same cycle, then tag 0 -> commits tags 0,1,2 in order on consecutive cycles. R1 stays pending until tag 2 commits.
- **Full and wrap (SIZE=8):** allocate 8 -> full=1 and a 9th new is rejected (tail unchanged). Notify and commit all 8, reallocate 3 -> tags 0,1,2 and count=3.
- **Exception flush:** allocate 4; tag1 notify exc=2; tags 0 and 1 complete -> tag0 commits, then tag1 commits with exc=2 and flush=1. A same-cycle new is dropped; next cycle count=0 and rob_wait=00 for all registers.
- **Duplicate notify:** both ports target tag0 with values 0x11 and 0x22 -> committed rval=0x22.
